// File: rtl/mac_unit_pipe.sv
// mac_unit_pipe: two-stage pipelined multiply-accumulate unit.
// Stage 1 registers the full-width product of A and B. Stage 2 sign- or
// zero-extends it and accumulates it. A dot product is framed every VEC_LEN
// accepted samples, and out_last marks the final value of each vector.
// overflow is sticky within a vector. A synchronous clear aborts the vector.
// Optional feature: define MAC_SATURATE_EN to clamp acc_out on overflow.
// Without MAC_SATURATE_EN, acc_out wraps modulo 2^ACC_W.
module mac_unit_pipe #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 4,
    parameter int SIGNED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              clear,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    output logic              out_last,
    output logic              overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(VEC_LEN - 1);

    // Stage-1 state
    logic [PROD_W-1:0] r_prod;
    logic              r_v1;
    logic              r_last1;
    logic [CNT_W-1:0]  r_cnt;

    // Stage-2 bookkeeping: next stage-2 sample starts a fresh vector
    logic              r_fresh;

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_sum;
    logic              w_carry;
    logic              w_add_ovf;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_cnt_at_end;

    assign w_cnt_at_end = (r_cnt == CNT_END);

    // The multiply and extension are the only places where signedness matters.
    // Operands are pre-extended to PROD_W so the truncated product is exact.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_prod     = $signed({{DATA_W{A[DATA_W-1]}}, A})
                              * $signed({{DATA_W{B[DATA_W-1]}}, B});
            assign w_prod_ext = ACC_W'($signed(r_prod));
            // Sign overflow: like-signed operands produce a result of the other sign.
            assign w_add_ovf  = (acc_out[ACC_W-1] == w_prod_ext[ACC_W-1])
                             && (w_sum[ACC_W-1] != acc_out[ACC_W-1]);
        end else begin : g_unsigned
            assign w_prod     = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
            assign w_prod_ext = ACC_W'(r_prod);
            assign w_add_ovf  = w_carry;
        end
    endgenerate

    assign {w_carry, w_sum} = {1'b0, acc_out} + {1'b0, w_prod_ext};

`ifdef MAC_SATURATE_EN
    logic [ACC_W-1:0] w_sat_val;

    // Clamp target: all-ones when unsigned. When signed, the extreme value on
    // the side the addend pushed toward (both operands share a sign on overflow).
    always_comb begin
        if (SIGNED == 0) begin
            w_sat_val = '1;
        end else if (w_prod_ext[ACC_W-1]) begin
            w_sat_val = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            w_sat_val = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`endif

    // Accumulator update for a non-first sample: clamp or wrap on overflow.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_acc_next = w_sum;
`ifdef MAC_SATURATE_EN
        if (w_add_ovf) begin
            w_acc_next = w_sat_val;
        end
`endif
    end

    // Stage 1: accept a sample, register its product, and track the position in the vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_prod  <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_cnt   <= '0;
        end else if (in_valid) begin
            r_prod  <= w_prod;
            r_v1    <= 1'b1;
            r_last1 <= w_cnt_at_end;
            r_cnt   <= w_cnt_at_end ? '0 : r_cnt + 1'b1;
        end else begin
            r_v1    <= 1'b0;
        end
    end

    // Stage 2: load or accumulate, raise the output pulses, and maintain the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
            r_fresh   <= 1'b1;
        end else if (clear) begin
            acc_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
            r_fresh   <= 1'b1;
        end else if (r_v1) begin
            out_valid <= 1'b1;
            out_last  <= r_last1;
            r_fresh   <= r_last1;
            if (r_fresh) begin
                acc_out  <= w_prod_ext;
                overflow <= 1'b0;
            end else begin
                acc_out  <= w_acc_next;
                overflow <= overflow | w_add_ovf;
            end
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_unit_pipe.sv
// tb_mac_unit_pipe: four configurations of mac_unit_pipe share one input stream.
// 0: default (8/24/4/unsigned)  1: ACC_W=16 unsigned  2: ACC_W=16 VEC_LEN=2 signed
// 3: VEC_LEN=1 unsigned. An arithmetic reference model predicts every cycle;
// directed vectors carry hand-computed literal expectations.
module tb_mac_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic [23:0] acc0;
    logic [15:0] acc1;
    logic [15:0] acc2;
    logic [23:0] acc3;
    logic [3:0]  o_valid;
    logic [3:0]  o_last;
    logic [3:0]  o_ovf;
    logic [23:0] dacc [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_unit_pipe #(.DATA_W(8), .ACC_W(24), .VEC_LEN(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clear(clear), .A(a), .B(b),
        .acc_out(acc0), .out_valid(o_valid[0]), .out_last(o_last[0]), .overflow(o_ovf[0]));
    mac_unit_pipe #(.DATA_W(8), .ACC_W(16), .VEC_LEN(4), .SIGNED(0)) u_ovf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clear(clear), .A(a), .B(b),
        .acc_out(acc1), .out_valid(o_valid[1]), .out_last(o_last[1]), .overflow(o_ovf[1]));
    mac_unit_pipe #(.DATA_W(8), .ACC_W(16), .VEC_LEN(2), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clear(clear), .A(a), .B(b),
        .acc_out(acc2), .out_valid(o_valid[2]), .out_last(o_last[2]), .overflow(o_ovf[2]));
    mac_unit_pipe #(.DATA_W(8), .ACC_W(24), .VEC_LEN(1), .SIGNED(0)) u_one (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clear(clear), .A(a), .B(b),
        .acc_out(acc3), .out_valid(o_valid[3]), .out_last(o_last[3]), .overflow(o_ovf[3]));

    assign dacc[0] = acc0;
    assign dacc[1] = {8'h00, acc1};
    assign dacc[2] = {8'h00, acc2};
    assign dacc[3] = acc3;

    int cfg_accw [4] = '{24, 16, 16, 24};
    int cfg_vlen [4] = '{4, 4, 2, 1};
    bit cfg_sgn  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef MAC_SATURATE_EN
    bit sat_mode = 1'b1;
`else
    bit sat_mode = 1'b0;
`endif

    // Reference model: mathematical accumulator value plus one in-flight sample per configuration.
    longint m_acc   [4];
    bit     m_ovf   [4];
    bit     m_valid [4];
    bit     m_last  [4];
    bit     m_fresh [4];
    int     m_cnt   [4];
    bit     p_v     [4];
    bit     p_last  [4];
    longint p_prod  [4];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint opnd(input logic [7:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    // Model advances on the same edges as the DUTs; reset is asynchronous as in the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0; m_ovf[k] = 0; m_valid[k] = 0; m_last[k] = 0;
                m_fresh[k] = 1; m_cnt[k] = 0; p_v[k] = 0; p_last[k] = 0; p_prod[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                longint lo, hi, span, sum, v;
                span = longint'(1) << cfg_accw[k];
                lo   = cfg_sgn[k] ? -(span / 2) : 0;
                hi   = cfg_sgn[k] ? (span / 2) - 1 : span - 1;
                if (clear) begin
                    m_acc[k] = 0; m_ovf[k] = 0; m_valid[k] = 0; m_last[k] = 0;
                    m_fresh[k] = 1; m_cnt[k] = 0; p_v[k] = 0;
                end else begin
                    if (p_v[k]) begin
                        if (m_fresh[k]) begin
                            m_acc[k] = p_prod[k];
                            m_ovf[k] = 0;
                        end else begin
                            sum = m_acc[k] + p_prod[k];
                            if (sum > hi || sum < lo) begin
                                m_ovf[k] = 1;
                                if (sat_mode) begin
                                    sum = (sum > hi) ? hi : lo;
                                end else begin
                                    v   = sum - lo;
                                    v   = ((v % span) + span) % span;
                                    sum = v + lo;
                                end
                            end
                            m_acc[k] = sum;
                        end
                        m_fresh[k] = p_last[k];
                        m_valid[k] = 1;
                        m_last[k]  = p_last[k];
                    end else begin
                        m_valid[k] = 0;
                        m_last[k]  = 0;
                    end
                    if (in_valid) begin
                        p_prod[k] = opnd(a, cfg_sgn[k]) * opnd(b, cfg_sgn[k]);
                        p_last[k] = (m_cnt[k] == cfg_vlen[k] - 1);
                        m_cnt[k]  = (m_cnt[k] + 1) % cfg_vlen[k];
                        p_v[k]    = 1;
                    end else begin
                        p_v[k]    = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all four configurations against the model.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                longint mask;
                mask = (longint'(1) << cfg_accw[k]) - 1;
                check($sformatf("cyc%0d_acc", k), longint'(dacc[k]), m_acc[k] & mask);
                check($sformatf("cyc%0d_valid", k), longint'(o_valid[k]), longint'(m_valid[k]));
                check($sformatf("cyc%0d_last", k), longint'(o_last[k]), longint'(m_last[k]));
                check($sformatf("cyc%0d_ovf", k), longint'(o_ovf[k]), longint'(m_ovf[k]));
            end
        end
    end

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic drive(input bit v, input logic [7:0] x, input logic [7:0] y, input bit c);
        in_valid = v; a = x; b = y; clear = c;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_acc", longint'(acc0), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_last", longint'(o_last), 0);
        check("rst_ovf", longint'(o_ovf), 0);
        rst = 1'b1;

        // Basic vector (5,3),(4,6),(5,4),(2,2)
        drive(1, 8'd5, 8'd3, 0);
        drive(1, 8'd4, 8'd6, 0);  check("v1_acc15", longint'(acc0), 15);
        check("v1_last_lo", longint'(o_last[0]), 0);
        drive(1, 8'd5, 8'd4, 0);  check("v1_acc39", longint'(acc0), 39);
        drive(1, 8'd2, 8'd2, 0);  check("v1_acc59", longint'(acc0), 59);
        drive(0, 8'd0, 8'd0, 0);  check("v1_acc63", longint'(acc0), 63);
        check("v1_last_hi", longint'(o_last[0]), 1);
        check("one_acc4", longint'(acc3), 4);
        check("one_last", longint'(o_last[3]), 1);

        // Same vector with a 3-cycle gap, then the next vector with no bubble
        drive(1, 8'd5, 8'd3, 0);
        drive(1, 8'd4, 8'd6, 0);
        drive(0, 8'd0, 8'd0, 0);
        drive(0, 8'd0, 8'd0, 0);  check("gap_hold39", longint'(acc0), 39);
        check("gap_novalid", longint'(o_valid[0]), 0);
        drive(0, 8'd0, 8'd0, 0);  check("gap_hold39b", longint'(acc0), 39);
        drive(1, 8'd5, 8'd4, 0);
        drive(1, 8'd2, 8'd2, 0);  check("gap_acc59", longint'(acc0), 59);
        drive(1, 8'd1, 8'd1, 0);  check("gap_acc63", longint'(acc0), 63);
        check("gap_last", longint'(o_last[0]), 1);
        drive(0, 8'd0, 8'd0, 0);  check("b2b_acc1", longint'(acc0), 1);
        check("b2b_ovf", longint'(o_ovf[0]), 0);

        // clear together with a valid sample mid-vector
        drive(1, 8'd2, 8'd3, 0);
        drive(1, 8'd7, 8'd7, 1);  check("clr_acc0", longint'(acc0), 0);
        check("clr_novalid", longint'(o_valid[0]), 0);
        drive(0, 8'd0, 8'd0, 0);  check("clr_drop_acc", longint'(acc0), 0);
        check("clr_drop_valid", longint'(o_valid[0]), 0);
        drive(1, 8'd1, 8'd2, 0);
        drive(1, 8'd3, 8'd4, 0);  check("clr_acc2", longint'(acc0), 2);
        drive(1, 8'd5, 8'd6, 0);  check("clr_acc14", longint'(acc0), 14);
        drive(1, 8'd7, 8'd8, 0);  check("clr_acc44", longint'(acc0), 44);
        check("clr_last_lo", longint'(o_last[0]), 0);
        drive(0, 8'd0, 8'd0, 0);  check("clr_acc100", longint'(acc0), 100);
        check("clr_last_hi", longint'(o_last[0]), 1);

        // Unsigned overflow with ACC_W=16
        drive(1, 8'd255, 8'd255, 0);
        drive(1, 8'd255, 8'd255, 0);  check("ovf_acc65025", longint'(acc1), 65025);
        check("ovf_pre", longint'(o_ovf[1]), 0);
        drive(1, 8'd0, 8'd0, 0);
`ifdef MAC_SATURATE_EN
        check("ovf_acc_sat", longint'(acc1), 65535);
`else
        check("ovf_acc_wrap", longint'(acc1), 64514);
`endif
        check("ovf_set", longint'(o_ovf[1]), 1);
        check("ovf_wide_acc", longint'(acc0), 130050);
        check("ovf_wide_flag", longint'(o_ovf[0]), 0);
        drive(1, 8'd0, 8'd0, 0);
        drive(0, 8'd0, 8'd0, 0);  check("ovf_sticky", longint'(o_ovf[1]), 1);
        check("ovf_last", longint'(o_last[1]), 1);
        drive(1, 8'd1, 8'd1, 0);
        drive(0, 8'd0, 8'd0, 0);  check("ovf_new_acc", longint'(acc1), 1);
        check("ovf_new_flag", longint'(o_ovf[1]), 0);

        // Signed overflow with ACC_W=16, VEC_LEN=2: (-128*-128) twice
        drive(0, 8'd0, 8'd0, 1);
        drive(1, 8'h80, 8'h80, 0);
        drive(1, 8'h80, 8'h80, 0);  check("sgn_acc16384", longint'(acc2), 16384);
        drive(0, 8'd0, 8'd0, 0);
`ifdef MAC_SATURATE_EN
        check("sgn_acc_sat", longint'(acc2), 32767);
`else
        check("sgn_acc_wrap", longint'(acc2), 32768);
`endif
        check("sgn_ovf", longint'(o_ovf[2]), 1);
        drive(1, 8'hFD, 8'h05, 0);
        drive(0, 8'd0, 8'd0, 0);  check("sgn_neg15", longint'(acc2), 16'hFFF1);
        check("sgn_ovf_clr", longint'(o_ovf[2]), 0);

        // Reset asserted mid-vector
        drive(1, 8'd3, 8'd3, 0);
        drive(1, 8'd3, 8'd3, 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mrst_acc", longint'(acc0), 0);
        check("mrst_valid", longint'(o_valid), 0);
        check("mrst_ovf", longint'(o_ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 8'd1, 8'd1, 0);
        drive(1, 8'd1, 8'd1, 0);
        drive(1, 8'd1, 8'd1, 0);
        drive(1, 8'd1, 8'd1, 0);  check("mrst_acc3", longint'(acc0), 3);
        check("mrst_last_lo", longint'(o_last[0]), 0);
        drive(0, 8'd0, 8'd0, 0);  check("mrst_acc4", longint'(acc0), 4);
        check("mrst_last_hi", longint'(o_last[0]), 1);
        drive(0, 8'd0, 8'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
